// File: rtl/pe_float_pkg.sv
// Shared floating-point definitions for the PE datapath operators:
// default field widths, bias, canonical qNaN, operand classes and flag bit indices.
package pe_float_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fclass_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN (sign 0, exponent all ones, fraction MSB set); caller truncates to W.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] r;
        r = ((128'd1 << exp_w) - 128'd1) << man_w;
        r = r | (128'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/pe_float_unpack.sv
// Combinational split/classify of one floating-point operand.
// Subnormals are reported as zero so downstream logic can flush them.
module pe_float_unpack
    import pe_float_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]     op_i,
    output logic             sign_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [MAN_W:0]   man_o,
    output fclass_e          cls_o
);

    logic [MAN_W-1:0] frac;

    assign sign_o = op_i[W-1];
    assign exp_o  = op_i[W-2 -: EXP_W];
    assign frac   = op_i[MAN_W-1:0];
    assign man_o  = {1'b1, frac};

    always_comb begin
        if (exp_o == '0) begin
            cls_o = CLS_ZERO;
        end else if (&exp_o) begin
            cls_o = (frac == '0) ? CLS_INF : CLS_NAN;
        end else begin
            cls_o = CLS_NORM;
        end
    end

endmodule

// File: rtl/pe_mult_float_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack / multiply / round+pack), RNE, FTZ.
// Define PE_MULT_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module pe_mult_float_pipe
    import pe_float_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] m
`ifdef PE_MULT_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int MW2  = MAN_W + 2;
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic [W-1:0]         QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

    logic                 sign_a, sign_b;
    logic [EXP_W-1:0]     exp_a, exp_b;
    logic [MAN_W:0]       man_a, man_b;
    fclass_e              cls_a, cls_b;

    logic                 adv;

    // Stage 1 carries the result class already resolved from both operand classes.
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q, s1_sign_d;
    logic signed [XW-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W:0]       s1_man_a_q, s1_man_a_d;
    logic [MAN_W:0]       s1_man_b_q, s1_man_b_d;
    fclass_e              s1_cls_q, s1_cls_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sign_q, s2_sign_d;
    logic signed [XW-1:0] s2_exp_q, s2_exp_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;
    fclass_e              s2_cls_q, s2_cls_d;

    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         m_q, m_d;

    logic [PW-1:0]        norm;
    logic [MAN_W:0]       mant;
    logic                 guard, sticky, round_up;
    logic [MAN_W+1:0]     mant_r;
    logic [MAN_W-1:0]     frac_r;
    logic signed [XW-1:0] exp_r;
    logic                 is_ovf, is_unf;

    pe_float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op_i   (a),
        .sign_o (sign_a),
        .exp_o  (exp_a),
        .man_o  (man_a),
        .cls_o  (cls_a)
    );

    pe_float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op_i   (b),
        .sign_o (sign_b),
        .exp_o  (exp_b),
        .man_o  (man_b),
        .cls_o  (cls_b)
    );

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign m         = m_q;

    always_comb begin
        s1_valid_d = in_valid;
        s1_sign_d  = sign_a ^ sign_b;
        s1_exp_d   = XW'(exp_a) + XW'(exp_b) - XW'(BIAS);
        s1_man_a_d = man_a;
        s1_man_b_d = man_b;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            s1_cls_d = CLS_NAN;
        end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            s1_cls_d = CLS_NAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            s1_cls_d = CLS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORM;
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_exp_d   = s1_exp_q;
        s2_cls_d   = s1_cls_q;
        s2_prod_d  = PW'(s1_man_a_q) * PW'(s1_man_b_q);
    end

    // Product lies in [1,4); left-align so the leading one sits at the MSB in both cases.
    always_comb begin
        norm     = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
        mant     = norm[PW-1 -: MAN_W+1];
        guard    = norm[PW-2-MAN_W];
        sticky   = |norm[PW-3-MAN_W:0];
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + MW2'(round_up);
        frac_r   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_r    = s2_exp_q + XW'(s2_prod_q[PW-1]) + XW'(mant_r[MAN_W+1]);
        is_ovf   = (exp_r >= EXP_MAX);
        is_unf   = (exp_r < EXP_ONE);
    end

    always_comb begin
        out_valid_d = s2_valid_q;
        m_d         = '0;
        case (s2_cls_q)
            CLS_NAN:  m_d = QNAN;
            CLS_INF:  m_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: m_d = {s2_sign_q, {(W-1){1'b0}}};
            default: begin
                if (is_ovf) begin
                    m_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (is_unf) begin
                    m_d = {s2_sign_q, {(W-1){1'b0}}};
                end else begin
                    m_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_a_q  <= '0;
            s1_man_b_q  <= '0;
            s1_cls_q    <= CLS_ZERO;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_cls_q    <= CLS_ZERO;
            out_valid_q <= 1'b0;
            m_q         <= '0;
        end else if (adv) begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_a_q  <= s1_man_a_d;
            s1_man_b_q  <= s1_man_b_d;
            s1_cls_q    <= s1_cls_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_cls_q    <= s2_cls_d;
            out_valid_q <= out_valid_d;
            m_q         <= m_d;
        end
    end

`ifdef PE_MULT_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    always_comb begin
        flags_d = '0;
        case (s2_cls_q)
            CLS_NAN: flags_d[FLG_INV] = 1'b1;
            CLS_NORM: begin
                if (is_ovf) begin
                    flags_d[FLG_OVF] = 1'b1;
                    flags_d[FLG_INX] = 1'b1;
                end else if (is_unf) begin
                    flags_d[FLG_UNF] = 1'b1;
                    flags_d[FLG_INX] = 1'b1;
                end else begin
                    flags_d[FLG_INX] = guard | sticky;
                end
            end
            default: flags_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (adv) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_pe_mult_float_pipe.sv
// Self-checking bench for pe_mult_float_pipe (binary32 defaults): directed cases, stall,
// mid-flight reset and randomized traffic against a real-arithmetic reference model.
`timescale 1ns/1ps
module tb_pe_mult_float_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [31:0] m;
`ifdef PE_MULT_FLAGS_EN
    logic [3:0]  flags;
    localparam logic [35:0] CMP_MASK = {36{1'b1}};
`else
    localparam logic [35:0] CMP_MASK = 36'h0_FFFF_FFFF;
`endif

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] res;
    } txn_t;
    txn_t exp_q[$];

    bit          hold_prev = 0;
    logic [31:0] m_prev = 32'h0;

    always #5 clk = ~clk;

    pe_mult_float_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m         (m)
`ifdef PE_MULT_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic check(input string nm, input logic [35:0] got, input logic [35:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    function automatic logic [35:0] obs();
`ifdef PE_MULT_FLAGS_EN
        return {flags, m};
`else
        return {4'b0000, m};
`endif
    endfunction

    // Exact value of a normal binary32 operand (magnitude) as a double.
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e11;
        e11 = 11'(int'(x[30:23]) - 127 + 1023);
        return $bitstoreal({1'b0, e11, x[22:0], 29'b0});
    endfunction

    // Reference: {invalid, overflow, underflow, inexact, result}. Product of two normals is exact
    // in double; it is then rounded to 24 significant bits with ties-to-even.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        bit          xz, xi, xn, yz, yi, yn, g, st;
        real         p;
        logic [63:0] pb;
        int          e;
        logic [24:0] keep;
        s  = x[31] ^ y[31];
        xz = (x[30:23] == 8'h00);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        yz = (y[30:23] == 8'h00);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
        if (xn || yn || (xi && yz) || (yi && xz)) return {4'b1000, 32'h7FC00000};
        if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
        if (xz || yz) return {4'b0000, s, 31'h0};
        p    = to_real(x) * to_real(y);
        pb   = $realtobits(p);
        e    = int'(pb[62:52]) - 1023 + 127;
        keep = {2'b01, pb[51:29]};
        g    = pb[28];
        st   = (pb[27:0] != 28'h0);
        if (g && (st || keep[0])) keep = keep + 25'd1;
        if (keep[24]) e++;
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0011, s, 31'h0};
        return {3'b000, (g || st), s, 8'(e), (keep[24] ? 23'h0 : keep[22:0])};
    endfunction

    // Single compare process: scoreboard on output transfers, hold check while stalled.
    always @(negedge clk) begin
        txn_t t;
        if (rst_n === 1'b1) begin
            if (hold_prev) begin
                check("stall_hold", {3'b000, out_valid, m}, {3'b000, 1'b1, m_prev});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got m=%h, want no output", m);
                end else begin
                    t = exp_q.pop_front();
                    check("result", obs(), t.res & CMP_MASK);
                    $display("xfer %0d: %h * %h -> m=%h", n_out, t.a, t.b, m);
                end
                n_out++;
            end
            hold_prev = out_valid && !out_ready;
            m_prev    = m;
            if (in_valid && in_ready) begin
                t.a   = a;
                t.b   = b;
                t.res = model(a, b);
                exp_q.push_back(t);
            end
        end else begin
            hold_prev = 0;
        end
    end

    task automatic directed(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input logic [35:0] want);
        check({nm, "_model"}, model(x, y), want);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 36'(in_ready), 36'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_lat1"}, 36'(out_valid), 36'd0);
        @(negedge clk);
        check({nm, "_lat2"}, 36'(out_valid), 36'd0);
        @(negedge clk);
        check({nm, "_lat3"}, 36'(out_valid), 36'd1);
        check({nm, "_m"}, obs(), want & CMP_MASK);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", 36'(exp_q.size()), 36'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic       s;
        logic [7:0] e;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'h0; end
            1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'h0; end
            2: e = 8'($urandom_range(1, 20));
            3: e = 8'($urandom_range(235, 254));
            4: begin e = 8'($urandom_range(120, 134)); f = (f & 23'h00000F) | 23'h7FFFF0; end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    logic [31:0] st_a [4] = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40A00000};
    logic [31:0] st_b [4] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h40A00000};

    initial begin : main
        int  k, cyc, sent, out0;
        bit  acc, saw_block;

        // Async reset assertion and reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_m", 36'(m), 36'd0);
        check("rst_in_ready", 36'(in_ready), 36'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        directed("mul_2p5x3",   32'h40200000, 32'h40400000, {4'b0000, 32'h40F00000});
        directed("mul_neg1p1x5", 32'hBF8CCCCD, 32'h40A00000, {4'b0001, 32'hC0B00000});
        directed("mul_x_zero",  32'h40400000, 32'h00000000, {4'b0000, 32'h00000000});
        directed("mul_negzero", 32'h80000000, 32'h40400000, {4'b0000, 32'h80000000});
        directed("mul_ovf",     32'h7F000000, 32'h40000000, {4'b0100, 32'h7F800000} | 36'h1_0000_0000);
        directed("mul_inf_zero", 32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000});
        directed("mul_nan",     32'hFFC12345, 32'h3F800000, {4'b1000, 32'h7FC00000});
        directed("mul_subn",    32'h00000001, 32'h40000000, {4'b0000, 32'h00000000});
        directed("mul_unf",     32'h00800000, 32'h3F000000, {4'b0011, 32'h00000000});
        directed("mul_inf_fin", 32'hFF800000, 32'h40000000, {4'b0000, 32'h7F800000} | 36'h0_8000_0000);
        drain();

        // Back-to-back issue into a stalled output
        out0      = n_out;
        out_ready = 1'b0;
        saw_block = 0;
        k         = 0;
        cyc       = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a        = st_a[0];
        b        = st_b[0];
        while (k < 4 && cyc < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (!in_ready) saw_block = 1;
            @(posedge clk); #1;
            cyc++;
            if (cyc >= 5) out_ready = 1'b1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    a = st_a[k];
                    b = st_b[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("stall_all_issued", 36'(k), 36'd4);
        check("stall_in_ready_drop", 36'(saw_block), 36'd1);
        drain();
        check("stall_out_count", 36'(n_out - out0), 36'd4);

        // Reset with three operations in flight
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = st_a[i];
            b        = st_b[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("inflight_before_rst", 36'(out_valid), 36'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_out_valid", 36'(out_valid), 36'd0);
        check("rst_async_m", 36'(m), 36'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 36'(out_valid), 36'd0);
        end
        directed("post_rst_mul", 32'h40200000, 32'h40400000, {4'b0000, 32'h40F00000});
        drain();

        // Randomized traffic with random backpressure
        sent = 0;
        cyc  = 0;
        out0 = n_out;
        while (sent < 300 && cyc < 20000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                if (sent < 300 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    a        = rnd_op();
                    b        = rnd_op();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("rand_all_sent", 36'(sent), 36'd300);
        drain();
        check("rand_out_count", 36'(n_out - out0), 36'd300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
